lcd_nibble_driver: RTL and testbench

Command-level driver for the HD44780-compatible character LCD on the Spartan-3E starter kit, wired in 4-bit mode. Sits directly downstream of the number/text writers: accepts one command or data byte per handshake, serialises it into one or two nibble strobes with datasheet setup, pulse and hold timing, then waits a caller-supplied settle delay before signalling ready again. Pin outputs go straight to the board LCD connector.

---
 rtl/lcd_nibble_driver_pkg.sv | 18 +
 rtl/lcd_cycle_timer.sv | 15 +
 rtl/lcd_nibble_driver.sv | 106 ++++++++++
 tb/tb_lcd_nibble_driver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_nibble_driver_pkg.sv
// lcd_nibble_driver_pkg: state encoding, timing defaults and HD44780 command bytes
package lcd_nibble_driver_pkg;
   typedef enum logic [3:0] {
      IDLE, SETUP_HI, PULSE_HI, HOLD_HI, GAP, SETUP_LO, PULSE_LO, HOLD_LO, DELAY
   } lcd_state_t;
   localparam int T_SETUP = 2;
   localparam int T_PULSE = 12;
   localparam int T_HOLD = 1;
   localparam int T_GAP = 50;
   localparam logic [7:0] FUNC_SET = 8'h28;
   localparam logic [7:0] ENTRY = 8'h06;
   localparam logic [7:0] DISP_ON = 8'h0C;
   localparam logic [7:0] CLEAR = 8'h01;
   // A state lasting n cycles loads n-1 so done rises on its final cycle.
   function automatic logic [31:0] ticks(input int n);
      return 32'(n - 1);
   endfunction
endpackage

// File: rtl/lcd_cycle_timer.sv
// lcd_cycle_timer: loadable 32-bit down-counter, done while the count is zero
module lcd_cycle_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] value,
   output logic        done
);
   logic [31:0] count;
   always_ff @(posedge clk)
      if (rst) count <= '0;
      else if (load) count <= value;
      else if (count != '0) count <= count - 1'b1;
   assign done = count == '0;
endmodule

// File: rtl/lcd_nibble_driver.sv
// lcd_nibble_driver: serialises one command/data byte into 4-bit HD44780 strobes
module lcd_nibble_driver
   import lcd_nibble_driver_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic        lcd_e,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic [3:0]  lcd_d,
   input  logic [7:0]  if_data,
   input  logic        if_rs,
   input  logic [31:0] if_delay,
   input  logic        if_8bit,
   input  logic        if_write,
   output logic        if_ready
);
   lcd_state_t  state;
   logic        armed;
   logic        eight_q;
   logic [3:0]  lo_q;
   logic [31:0] delay_q;
   logic        load;
   logic        done;
   logic [31:0] load_val;
   assign lcd_rw = 1'b0;
   // The timer is reloaded with the length of whatever state comes next.
   assign load = state == IDLE || done;
   always_comb begin
      load_val = ticks(T_SETUP);
      case (state)
         SETUP_HI, SETUP_LO: load_val = ticks(T_PULSE);
         PULSE_HI, PULSE_LO: load_val = ticks(T_HOLD);
         HOLD_HI:            load_val = eight_q ? ticks(T_GAP) : delay_q - 1'b1;
         HOLD_LO:            load_val = delay_q - 1'b1;
         default:            load_val = ticks(T_SETUP);
      endcase
   end
   lcd_cycle_timer u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .value (load_val),
      .done  (done)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         armed    <= 1'b1;
         eight_q  <= 1'b0;
         lo_q     <= '0;
         delay_q  <= '0;
         lcd_e    <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_d    <= '0;
         if_ready <= 1'b1;
      end else begin
         if (!if_write) armed <= 1'b1;
         case (state)
            IDLE: if (if_write && armed) begin
               eight_q  <= if_8bit;
               lo_q     <= if_data[3:0];
               delay_q  <= if_delay;
               lcd_rs   <= if_rs;
               lcd_d    <= if_data[7:4];
               armed    <= 1'b0;
               if_ready <= 1'b0;
               state    <= SETUP_HI;
            end
            SETUP_HI: if (done) begin
               lcd_e <= 1'b1;
               state <= PULSE_HI;
            end
            PULSE_HI: if (done) begin
               lcd_e <= 1'b0;
               state <= HOLD_HI;
            end
            HOLD_HI: if (done) begin
               state    <= eight_q ? GAP : delay_q == '0 ? IDLE : DELAY;
               if_ready <= !eight_q && delay_q == '0;
            end
            GAP: if (done) begin
               lcd_d <= lo_q;
               state <= SETUP_LO;
            end
            SETUP_LO: if (done) begin
               lcd_e <= 1'b1;
               state <= PULSE_LO;
            end
            PULSE_LO: if (done) begin
               lcd_e <= 1'b0;
               state <= HOLD_LO;
            end
            HOLD_LO: if (done) begin
               state    <= delay_q == '0 ? IDLE : DELAY;
               if_ready <= delay_q == '0;
            end
            DELAY: if (done) begin
               if_ready <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_nibble_driver.sv
// tb_lcd_nibble_driver: per-cycle offset model of the strobe timeline plus directed literal checks
module tb_lcd_nibble_driver;
   import lcd_nibble_driver_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lcd_e, lcd_rs, lcd_rw, if_ready;
   logic [3:0]  lcd_d;
   logic [7:0]  if_data = '0;
   logic        if_rs = 1'b0;
   logic [31:0] if_delay = '0;
   logic        if_8bit = 1'b0;
   logic        if_write = 1'b0;
   int          checks = 0;
   int          failures = 0;
   longint      cyc = 0;
   longint      low;
   always #10 clk = ~clk;
   lcd_nibble_driver dut (
      .clk      (clk),
      .rst      (rst),
      .lcd_e    (lcd_e),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_d    (lcd_d),
      .if_data  (if_data),
      .if_rs    (if_rs),
      .if_delay (if_delay),
      .if_8bit  (if_8bit),
      .if_write (if_write),
      .if_ready (if_ready)
   );
   // Model: m_off is the cycle number since accept (-1 when idle); outputs follow from it.
   longint     m_off = -1, m_len = 0;
   logic       m_armed = 1'b1, m_rs = 1'b0, m_eight = 1'b0;
   logic [3:0] m_hi = '0, m_lo = '0, m_idle_d = '0;
   always begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
         m_off = -1; m_armed = 1'b1; m_rs = 1'b0; m_idle_d = '0; m_eight = 1'b0;
      end else begin
         if (m_off < 0 && if_write && m_armed) begin
            m_off = 1;
            m_len = (if_8bit ? 80 : 15) + longint'(if_delay);
            m_hi = if_data[7:4]; m_lo = if_data[3:0]; m_rs = if_rs; m_eight = if_8bit;
         end else if (m_off >= 0) begin
            if (m_off >= m_len) begin
               m_off = -1;
               m_idle_d = m_eight ? m_lo : m_hi;
            end else m_off = m_off + 1;
         end
         m_armed = !if_write || (m_armed && !(m_off == 1 && if_write));
      end
   end
   logic       x_e, x_rdy;
   logic [3:0] x_d;
   always begin
      @(negedge clk);
      x_rdy = m_off < 0;
      x_e = (m_off >= 3 && m_off <= 14) || (m_eight && m_off >= 68 && m_off <= 79);
      x_d = m_off < 0 ? m_idle_d : (m_eight && m_off >= 66) ? m_lo : m_hi;
      checks++;
      if ({lcd_e, lcd_rs, lcd_rw, lcd_d, if_ready} !== {x_e, m_rs, 1'b0, x_d, x_rdy}) begin
         failures++;
         if (failures <= 20)
            $display("FAIL model cyc=%0d got e=%b rs=%b rw=%b d=%h rdy=%b expected e=%b rs=%b rw=0 d=%h rdy=%b",
                     cyc, lcd_e, lcd_rs, lcd_rw, lcd_d, if_ready, x_e, m_rs, x_d, x_rdy);
      end
   end
   typedef struct {logic [3:0] d; logic rs; int width; longint start;} pulse_t;
   pulse_t pq[$];
   pulse_t cur;
   logic   prev_e = 1'b0;
   always begin
      @(negedge clk);
      if (lcd_e && !prev_e) begin
         cur.d = lcd_d; cur.rs = lcd_rs; cur.width = 1; cur.start = cyc;
      end else if (lcd_e) cur.width++;
      else if (prev_e) pq.push_back(cur);
      prev_e = lcd_e;
   end
   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask
   task automatic xfer(input logic [7:0] data, input logic rs, input logic eight,
                       input logic [31:0] dly, output longint n);
      @(negedge clk);
      if_data = data; if_rs = rs; if_8bit = eight; if_delay = dly; if_write = 1'b1;
      @(negedge clk);
      if_write = 1'b0;
      n = 0;
      while (!if_ready && n < 200000) begin
         n++;
         @(negedge clk);
      end
   endtask
   task automatic chk_pulse(input string name, input int idx, input logic [3:0] d,
                            input logic rs, input int width);
      if (pq.size() > idx) begin
         chk({name, "_d"}, pq[idx].d, d);
         chk({name, "_rs"}, pq[idx].rs, rs);
         chk({name, "_width"}, pq[idx].width, width);
      end
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_e", lcd_e, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_rw", lcd_rw, 0);
      chk("rst_d", lcd_d, 0);
      chk("rst_ready", if_ready, 1);
      rst = 1'b0;
      // 8-bit command with long settle
      pq.delete();
      xfer(FUNC_SET, 1'b0, 1'b1, 32'd20000, low);
      chk("func_busy", low, 20080);
      chk("func_pulses", pq.size(), 2);
      chk_pulse("func_p0", 0, 4'h2, 1'b0, 12);
      chk_pulse("func_p1", 1, 4'h8, 1'b0, 12);
      if (pq.size() == 2) chk("func_spacing", pq[1].start - pq[0].start, 65);
      // 4-bit, zero delay
      pq.delete();
      xfer(8'h30, 1'b0, 1'b0, 32'd0, low);
      chk("nib_busy", low, 15);
      chk("nib_pulses", pq.size(), 1);
      chk_pulse("nib_p0", 0, 4'h3, 1'b0, 12);
      // held request: only one transfer until it drops
      pq.delete();
      @(negedge clk);
      if_data = 8'h41; if_rs = 1'b1; if_8bit = 1'b1; if_delay = 32'd5; if_write = 1'b1;
      repeat (200) @(negedge clk);
      chk("held_ready", if_ready, 1);
      chk("held_pulses", pq.size(), 2);
      chk_pulse("held_p0", 0, 4'h4, 1'b1, 12);
      chk_pulse("held_p1", 1, 4'h1, 1'b1, 12);
      if_write = 1'b0;
      @(negedge clk);
      xfer(8'h41, 1'b1, 1'b1, 32'd5, low);
      chk("rearm_busy", low, 85);
      chk("rearm_pulses", pq.size(), 4);
      // writes pulsed while busy are ignored
      pq.delete();
      @(negedge clk);
      if_data = 8'h5A; if_rs = 1'b1; if_8bit = 1'b1; if_delay = 32'd10; if_write = 1'b1;
      @(negedge clk);
      if_write = 1'b0;
      low = 0;
      while (!if_ready && low < 1000) begin
         if_write = ~if_write; if_data = 8'hFF; if_rs = 1'b0;
         low++;
         @(negedge clk);
      end
      if_write = 1'b0;
      chk("busy_ignore_busy", low, 90);
      chk("busy_ignore_pulses", pq.size(), 2);
      chk_pulse("busy_p0", 0, 4'h5, 1'b1, 12);
      chk_pulse("busy_p1", 1, 4'hA, 1'b1, 12);
      // reset in the middle of the lower strobe
      pq.delete();
      @(negedge clk);
      if_data = 8'h6A; if_rs = 1'b1; if_8bit = 1'b1; if_delay = 32'd100; if_write = 1'b1;
      @(negedge clk);
      if_write = 1'b0;
      repeat (69) @(negedge clk);
      chk("midrst_e_before", lcd_e, 1);
      chk("midrst_d_before", lcd_d, 4'hA);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_e", lcd_e, 0);
      chk("midrst_d", lcd_d, 0);
      chk("midrst_rs", lcd_rs, 0);
      chk("midrst_ready", if_ready, 1);
      @(negedge clk);
      chk("midrst_pulses", pq.size(), 2);
      if (pq.size() == 2) chk("midrst_cut_width", pq[1].width, 3);
      pq.delete();
      xfer(DISP_ON, 1'b0, 1'b1, 32'd5, low);
      chk("disp_busy", low, 85);
      chk("disp_pulses", pq.size(), 2);
      chk_pulse("disp_p0", 0, 4'h0, 1'b0, 12);
      chk_pulse("disp_p1", 1, 4'hC, 1'b0, 12);
      // delay boundaries
      xfer(CLEAR, 1'b0, 1'b1, 32'd1, low);
      chk("d1_busy", low, 81);
      xfer(ENTRY, 1'b0, 1'b1, 32'd30000, low);
      chk("dlarge_busy", low, 30080);
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #(64'd4_000_000);
      $display("FAIL timeout cyc=%0d expected finish before cycle 200000", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end
endmodule
